// File: rtl/key_int_pkg.sv
// rtl/key_int_pkg.sv - register map constants shared by the key interrupt controller
//
// Purpose: register select codes, CTRL bit positions and a key-mask helper.
// Ports: none (package).

package key_int_pkg;

    // Register select codes.
    // On the write side SEL_PEND addresses PEND_CLR (write-1-to-clear).
    localparam logic [1:0] SEL_CTRL  = 2'd0;
    localparam logic [1:0] SEL_PEND  = 2'd1;
    localparam logic [1:0] SEL_EN    = 2'd2;
    localparam logic [1:0] SEL_STATE = 2'd3;

    // CTRL bit positions
    localparam int CTRL_GIE    = 0;
    localparam int CTRL_REL_EN = 1;

    // Byte mask with the low n bits set; keeps unimplemented key bits at 0
    function automatic logic [7:0] key_mask(input int n);
        logic [7:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < n) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - two-flop synchroniser plus stable-level debounce for one key
//
// Purpose: accept a new key level only after it has differed from the current
//          stable level for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous active-high reset
//   raw     in   asynchronous raw key level
//   stable  out  debounced level

module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          stable_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The counter never passes CNT_LAST: reaching it either commits the new
    // level or the mismatch has already ended, so it cannot wrap.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/key_int_ctrl.sv
// rtl/key_int_ctrl.sv - memory-mapped key interrupt controller driving keyInt
//
// Purpose: debounce up to 8 keys, latch qualified press/release edges in
//          PENDING and pulse key_int once per newly pending key.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   keys_in  in   raw key levels, 1 = pressed
//   wr_en    in   write strobe
//   wr_sel   in   write select: CTRL, PEND_CLR, EN_MASK, reserved
//   wr_data  in   write data
//   rd_sel   in   read select: CTRL, PENDING, EN_MASK, KEY_STATE
//   rd_data  out  registered read data (1-cycle latency)
//   key_int  out  single-cycle interrupt pulse

module key_int_ctrl
    import key_int_pkg::*;
#(
    parameter int NUM_KEYS        = 8,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] keys_in,
    input  logic                wr_en,
    input  logic [1:0]          wr_sel,
    input  logic [7:0]          wr_data,
    input  logic [1:0]          rd_sel,
    output logic [7:0]          rd_data,
    output logic                key_int
);

    localparam logic [7:0] KEY_MASK = key_mask(NUM_KEYS);

    logic [7:0] stable_w;
    logic [7:0] stable_prev_q;
    logic [1:0] ctrl_q,      ctrl_d;
    logic [7:0] en_q,        en_d;
    logic [7:0] pend_q,      pend_d;
    logic [7:0] pend_prev_q;
    logic [7:0] rd_data_q,   rd_data_d;
    logic       key_int_q,   key_int_d;
    logic [7:0] press_w;
    logic [7:0] release_w;
    logic [7:0] qual_w;

    // Unimplemented key positions are tied low so they never produce edges
    for (genvar gi = 0; gi < 8; gi++) begin : g_key
        if (gi < NUM_KEYS) begin : g_used
            key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk    (clk),
                .rst    (rst),
                .raw    (keys_in[gi]),
                .stable (stable_w[gi])
            );
        end else begin : g_unused
            assign stable_w[gi] = 1'b0;
        end
    end

    always_comb begin
        press_w   = stable_w & ~stable_prev_q;
        release_w = ~stable_w & stable_prev_q;
        qual_w    = en_q & (press_w | (release_w & {8{ctrl_q[CTRL_REL_EN]}}));

        ctrl_d = ctrl_q;
        en_d   = en_q;
        pend_d = pend_q;
        if (wr_en) begin
            case (wr_sel)
                SEL_CTRL: ctrl_d = wr_data[1:0];
                SEL_PEND: pend_d = pend_q & ~wr_data;
                SEL_EN:   en_d   = wr_data & KEY_MASK;
                default:  ;
            endcase
        end
        // Set after clear so a same-cycle edge wins over the clear
        pend_d = pend_d | qual_w;

        // Fires only on fresh 0->1 transitions seen one cycle earlier
        key_int_d = ctrl_q[CTRL_GIE] & (|(pend_q & ~pend_prev_q));

        // Reads sample pre-write register values
        case (rd_sel)
            SEL_CTRL: rd_data_d = {6'b0, ctrl_q};
            SEL_PEND: rd_data_d = pend_q;
            SEL_EN:   rd_data_d = en_q;
            default:  rd_data_d = stable_w;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_prev_q <= '0;
            ctrl_q        <= '0;
            en_q          <= '0;
            pend_q        <= '0;
            pend_prev_q   <= '0;
            rd_data_q     <= '0;
            key_int_q     <= 1'b0;
        end else begin
            stable_prev_q <= stable_w;
            ctrl_q        <= ctrl_d;
            en_q          <= en_d;
            pend_q        <= pend_d;
            pend_prev_q   <= pend_q;
            rd_data_q     <= rd_data_d;
            key_int_q     <= key_int_d;
        end
    end

    assign rd_data = rd_data_q;
    assign key_int = key_int_q;

endmodule

// File: tb/tb_key_int_ctrl.sv
// tb/tb_key_int_ctrl.sv - self-checking bench for key_int_ctrl

module tb_key_int_ctrl;
    import key_int_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] keys_in = '0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_sel = '0;
    logic [7:0] wr_data = '0;
    logic [1:0] rd_sel = '0;
    logic [7:0] rd_data;
    logic       key_int;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int         due;
        bit         is_int;
        logic [7:0] exp;
        string      tag;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        bit         do_wr;
        logic [1:0] wsel;
        logic [7:0] wdata;
        logic [1:0] rsel;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[$];

    key_int_ctrl #(
        .NUM_KEYS        (8),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .keys_in (keys_in),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_data (wr_data),
        .rd_sel  (rd_sel),
        .rd_data (rd_data),
        .key_int (key_int)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard drain: compare expectations that fall due in this cycle
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            sb_t e;
            e = sb.pop_front();
            if (e.due != cyc)
                check({e.tag, "/late"}, e.due, cyc);
            else if (e.is_int)
                check({e.tag, "/key_int"}, {31'b0, key_int}, {24'b0, e.exp});
            else
                check({e.tag, "/rd_data"}, {24'b0, rd_data}, {24'b0, e.exp});
        end
    end

    // One cycle: choose rd_sel, queue what must appear after the next edge
    task automatic cyc_exp(input bit chk_rd, input logic [1:0] rsel, input logic [7:0] exp_rd,
                           input bit exp_int, input string tag);
        rd_sel = rsel;
        if (chk_rd) sb.push_back('{cyc + 1, 1'b0, exp_rd, tag});
        sb.push_back('{cyc + 1, 1'b1, {7'b0, exp_int}, tag});
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic wr_cyc(input logic [1:0] sel, input logic [7:0] data, input logic [1:0] rsel,
                          input logic [7:0] exp_rd, input string tag);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_data = data;
        cyc_exp(1'b1, rsel, exp_rd, 1'b0, tag);
    endtask

    // Change one key and follow it for 10 cycles (debounce 4):
    // stable flips at edge 6, PENDING at edge 7, key_int at edge 8.
    task automatic key_event(input int key, input logic lvl,
                             input logic [7:0] st_b, input logic [7:0] st_a,
                             input logic [7:0] pd_b, input logic [7:0] pd_a,
                             input bit exp_int, input logic [7:0] clr, input string tag);
        keys_in[key] = lvl;
        for (int k = 0; k < 10; k++) begin
            if (k == 6 && clr != 8'h00) begin
                wr_en   = 1'b1;
                wr_sel  = SEL_PEND;
                wr_data = clr;
            end
            if (k < 5)
                cyc_exp(1'b1, SEL_PEND, pd_b, 1'b0, tag);
            else if (k < 7)
                cyc_exp(1'b1, SEL_STATE, (k == 5) ? st_b : st_a, 1'b0, tag);
            else
                cyc_exp(1'b1, SEL_PEND, pd_a, (k == 7) ? exp_int : 1'b0, tag);
        end
    endtask

    initial begin
        vecs.push_back('{1'b1, SEL_CTRL,  8'hFF, SEL_CTRL,  8'h03});
        vecs.push_back('{1'b1, SEL_EN,    8'hA5, SEL_EN,    8'hA5});
        vecs.push_back('{1'b1, 2'd3,      8'hFF, SEL_CTRL,  8'h03});
        vecs.push_back('{1'b0, SEL_CTRL,  8'h00, SEL_EN,    8'hA5});
        vecs.push_back('{1'b1, SEL_CTRL,  8'h00, SEL_CTRL,  8'h00});
        vecs.push_back('{1'b1, SEL_EN,    8'h00, SEL_EN,    8'h00});
        vecs.push_back('{1'b0, SEL_CTRL,  8'h00, SEL_PEND,  8'h00});
        vecs.push_back('{1'b0, SEL_CTRL,  8'h00, SEL_STATE, 8'h00});
        vecs.push_back('{1'b1, SEL_PEND,  8'hFF, SEL_PEND,  8'h00});

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset/rd_data", {24'b0, rd_data}, 32'h0);
        check("reset/key_int", {31'b0, key_int}, 32'h0);
        rst = 1'b0;

        // Register table: write (if any), then read back
        foreach (vecs[i]) begin
            if (vecs[i].do_wr) begin
                wr_en   = 1'b1;
                wr_sel  = vecs[i].wsel;
                wr_data = vecs[i].wdata;
                cyc_exp(1'b0, SEL_CTRL, 8'h00, 1'b0, "tbl_wr");
            end
            cyc_exp(1'b1, vecs[i].rsel, vecs[i].exp, 1'b0, $sformatf("tbl%0d", i));
        end

        // Basic press of key 0 with GIE and EN_MASK bit 0
        wr_cyc(SEL_CTRL, 8'h01, SEL_CTRL, 8'h00, "cfg_gie");
        wr_cyc(SEL_EN,   8'h01, SEL_CTRL, 8'h01, "cfg_en");
        key_event(0, 1'b1, 8'h00, 8'h01, 8'h00, 8'h01, 1'b1, 8'h00, "press0");

        // Glitch on key 1 shorter than the debounce window
        wr_cyc(SEL_EN, 8'hFF, SEL_PEND, 8'h01, "en_all");
        keys_in[1] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k == 3) keys_in[1] = 1'b0;
            cyc_exp(1'b1, (k % 2 == 0) ? SEL_STATE : SEL_PEND, 8'h01, 1'b0, "glitch1");
        end

        // Second key while key 0 pending, then W1C of bit 0
        key_event(2, 1'b1, 8'h01, 8'h05, 8'h01, 8'h05, 1'b1, 8'h00, "press2");
        wr_cyc(SEL_PEND, 8'h01, SEL_PEND, 8'h05, "clr0_pre");
        cyc_exp(1'b1, SEL_PEND, 8'h04, 1'b0, "clr0_post");

        // Release without REL_EN is ignored; with REL_EN both edges latch
        key_event(0, 1'b0, 8'h05, 8'h04, 8'h04, 8'h04, 1'b0, 8'h00, "rel_off");
        wr_cyc(SEL_CTRL, 8'h03, SEL_PEND, 8'h04, "rel_en");
        wr_cyc(SEL_PEND, 8'hFF, SEL_CTRL, 8'h03, "clr_all");
        key_event(0, 1'b1, 8'h04, 8'h05, 8'h00, 8'h01, 1'b1, 8'h00, "rel_press");
        wr_cyc(SEL_PEND, 8'h01, SEL_PEND, 8'h01, "clr0b");
        key_event(0, 1'b0, 8'h05, 8'h04, 8'h00, 8'h01, 1'b1, 8'h00, "rel_rel");

        // Clear and qualified edge on key 3 in the same cycle: set wins
        key_event(3, 1'b1, 8'h04, 8'h0C, 8'h01, 8'h09, 1'b1, 8'h08, "clr_vs_set");

        // GIE off: pending latches silently; enabling GIE later does not fire
        wr_cyc(SEL_CTRL, 8'h00, SEL_PEND, 8'h09, "gie_off");
        wr_cyc(SEL_PEND, 8'hFF, SEL_CTRL, 8'h00, "clr_all2");
        key_event(4, 1'b1, 8'h0C, 8'h1C, 8'h00, 8'h10, 1'b0, 8'h00, "press4_nogie");
        wr_cyc(SEL_CTRL, 8'h01, SEL_PEND, 8'h10, "gie_on");
        cyc_exp(1'b1, SEL_CTRL, 8'h01, 1'b0, "gie_rd");
        for (int k = 0; k < 6; k++)
            cyc_exp(1'b1, SEL_PEND, 8'h10, 1'b0, "gie_late");

        // Reset in the middle of key 5's debounce
        keys_in[5] = 1'b1;
        for (int k = 0; k < 3; k++)
            cyc_exp(1'b1, SEL_PEND, 8'h10, 1'b0, "pre_rst");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst/rd_data", {24'b0, rd_data}, 32'h0);
        check("midrst/key_int", {31'b0, key_int}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        keys_in = 8'h20;
        for (int k = 0; k < 12; k++) begin
            if (k == 3) keys_in = 8'h00;
            cyc_exp(1'b1, 2'(k), 8'h00, 1'b0, "post_rst");
        end

        @(negedge clk);
        #1;
        check("sb_drain", sb.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
